// File: rtl/tx_engine.sv
// UART transmit engine: captures a byte on a load strobe, builds an 11-bit
// frame (start, 7/8 data bits, optional parity, stop bits) and shifts it out
// LSB-first on tx, one bit every k clocks.
module tx_engine #(
  parameter int K_WIDTH = 19
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [7:0]         out_port,
  input  logic [K_WIDTH-1:0] k,
  input  logic               eight,
  input  logic               pen,
  input  logic               ohel,
  output logic               tx,
  output logic               tx_rdy
);

  logic [7:0]         data_q;
  logic               eight_q;
  logic               pen_q;
  logic               ohel_q;
  logic               build_q;
  logic [10:0]        shift_q;
  logic [K_WIDTH-1:0] bt_cnt;
  logic [3:0]         bit_cnt;
  logic               doit;

  logic [K_WIDTH-1:0] k_eff;
  logic               btu;
  logic               par;
  logic               b8;
  logic               b9;
  logic [10:0]        frame;

  // Divisor clamp, bit-time pulse and frame assembly from the captured copy.
  always_comb begin
    k_eff = (k < K_WIDTH'(2)) ? K_WIDTH'(2) : k;
    btu   = doit && (bt_cnt == k_eff - K_WIDTH'(1));
    par   = (eight_q ? ^data_q : ^data_q[6:0]) ^ ohel_q;
    b8    = eight_q ? data_q[7] : (pen_q ? par : 1'b1);
    b9    = (eight_q && pen_q) ? par : 1'b1;
    frame = {1'b1, b9, b8, data_q[6:0], 1'b0};
  end

  // Capture on load, build the frame one cycle later, then shift on each btu.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      eight_q <= 1'b0;
      pen_q   <= 1'b0;
      ohel_q  <= 1'b0;
      build_q <= 1'b0;
      shift_q <= '1;
      bt_cnt  <= '0;
      bit_cnt <= '0;
      doit    <= 1'b0;
      tx_rdy  <= 1'b1;
    end else begin
      if (load && tx_rdy) begin
        data_q  <= out_port;
        eight_q <= eight;
        pen_q   <= pen;
        ohel_q  <= ohel;
        build_q <= 1'b1;
        tx_rdy  <= 1'b0;
      end
      if (build_q) begin
        shift_q <= frame;
        doit    <= 1'b1;
        build_q <= 1'b0;
      end
      if (doit) begin
        if (btu) begin
          bt_cnt  <= '0;
          shift_q <= {1'b1, shift_q[10:1]};
          if (bit_cnt == 4'd10) begin
            bit_cnt <= '0;
            doit    <= 1'b0;
            tx_rdy  <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
          end
        end else begin
          bt_cnt <= bt_cnt + K_WIDTH'(1);
        end
      end
    end
  end

  assign tx = shift_q[0];

endmodule
